midi_tx_buffer: RTL

Buffered MIDI-out transmitter between `midi_decoder` and the MIDI OUT opto driver. It accepts bytes from the decoder's `midi_send_byte`/`midi_out_data` strobe, typically sysex patch-dump bursts, into a small FIFO. It serialises each byte as an 8N1 frame at 31250 baud on `midi_txd` and returns `midi_out_ready` for flow control. All logic runs in the `CLOCK_25` domain.

---
 rtl/midi_pkg.sv | 14 +
 rtl/utils.sv | 17 +
 rtl/midi_byte_fifo.sv | 56 +++++
 rtl/midi_tx_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// MIDI line constants and the transmitter state encoding shared by the MIDI blocks.
package midi_pkg;

    localparam int MIDI_BAUD       = 31250;
    localparam int MIDI_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/utils.sv
// Shared elaboration-time helpers used across the MIDI slice.
package utils;

    // Ceiling log2: number of bits needed to index 'value' distinct states.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// Synchronous show-ahead byte FIFO with wrap-bit pointers, fill level and full/empty flags.
// reset1 is active-low and sampled on sysclk.
module midi_byte_fifo
    import utils::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clogb2(DEPTH)
) (
    input  logic             sysclk,
    input  logic             reset1,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_ff @(posedge sysclk) begin
        if (!reset1) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset1 && wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/midi_tx_buffer.sv
// Buffered MIDI OUT: queues decoder bytes in a FIFO and serialises them as 8N1 frames.
// Handshake: a byte is taken on any cycle where midi_send_byte and midi_out_ready are both high.
module midi_tx_buffer
    import utils::*;
    import midi_pkg::*;
#(
    parameter  int CLK_HZ = 25_000_000,
    parameter  int BAUD   = MIDI_BAUD,
    parameter  int DEPTH  = 16,
    localparam int LW     = clogb2(DEPTH) + 1
) (
    input  logic          CLOCK_25,
    input  logic          reset_reg_N,
    input  logic          midi_send_byte,
    input  logic [7:0]    midi_out_data,
    output logic          midi_out_ready,
    output logic          midi_txd,
    output logic          tx_busy,
    output logic [LW-1:0] fifo_level,
    output logic          overflow
);

    localparam int            DIV       = CLK_HZ / BAUD;
    localparam int            CW        = clogb2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(MIDI_FRAME_BITS - 3);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          bit_last;
    logic          pop;

    midi_byte_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sysclk  (CLOCK_25),
        .reset1  (reset_reg_N),
        .wr_en   (midi_send_byte),
        .wr_data (midi_out_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bit_last       = (cnt == CNT_LAST);
    assign midi_out_ready = !fifo_full;
    assign tx_busy        = (state != S_IDLE) || !fifo_empty;

    // Pop from IDLE, or on the final stop-bit cycle so frames run back to back.
    assign pop = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_last));

    always_ff @(posedge CLOCK_25) begin
        if (!reset_reg_N) begin
            overflow <= 1'b0;
        end else if (midi_send_byte && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (!reset_reg_N) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            midi_txd <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shreg    <= head;
                        midi_txd <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        midi_txd <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            midi_txd <= 1'b1;
                            state    <= S_STOP;
                        end else begin
                            // Line bit already holds shreg[0]; the next one comes from shreg[1].
                            shreg    <= {1'b0, shreg[7:1]};
                            midi_txd <= shreg[1];
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_last) begin
                        cnt <= '0;
                        if (!fifo_empty) begin
                            shreg    <= head;
                            midi_txd <= 1'b0;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    midi_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule
